// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
// Optional FETCH_STATS_EN adds fetched/stall/redirect event counters.
//
// state | meaning
// BOOT  | first cycle after reset; memory's latched address untrusted, re-issue it
// RUN   | one word per cycle, honouring stall and redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] r_addr,
  input  logic [31:0] ins,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_redirects
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] next_pc;

  always_comb begin
    if (state == BOOT)
      next_pc = fetch_pc;
    else if (redirect)
      next_pc = redirect_pc & 32'hFFFF_FFFC;
    else if (stall)
      next_pc = fetch_pc;
    else
      next_pc = fetch_pc + 32'd4;
  end

  assign r_addr = {2'b00, next_pc[31:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_ins   <= 32'd0;
    end else begin
      fetch_pc <= next_pc;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          // redirect kills the wrong-path word already in flight from memory
          if (redirect) begin
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_valid <= 1'b1;
            if_pc    <= fetch_pc;
            if_ins   <= ins;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched   <= 32'd0;
      stat_stalls    <= 32'd0;
      stat_redirects <= 32'd0;
    end else if (state == RUN) begin
      if (redirect)
        stat_redirects <= stat_redirects + 32'd1;
      else if (stall)
        stat_stalls <= stat_stalls + 32'd1;
      else
        stat_fetched <= stat_fetched + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/redirect traffic against a PC-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] r_addr;
  logic [31:0] ins;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stalls, stat_redirects;
`endif

  int total = 0;
  int bad   = 0;

  // memory: word k holds 32'h1000_0000 + k, one-cycle read latency
  logic [31:0] mem_lat = 32'd0;
  always @(posedge clk) mem_lat <= r_addr;
  assign ins = 32'h1000_0000 + mem_lat;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .r_addr(r_addr), .ins(ins),
    .if_valid(if_valid), .if_pc(if_pc), .if_ins(if_ins)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stalls(stat_stalls), .stat_redirects(stat_redirects)
`endif
  );

  // reference model: address memory is currently serving, boot flag, expected IF/ID
  bit          m_boot;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_pc, m_ins;
  int          m_fetched, m_stalls, m_redirects;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return 32'h1000_0000 + (byte_addr >> 2);
  endfunction

  task automatic model_reset();
    m_boot = 1; m_addr = 32'h0; m_valid = 0; m_pc = 0; m_ins = 0;
    m_fetched = 0; m_stalls = 0; m_redirects = 0;
  endtask

  function automatic logic [31:0] model_next(input logic s, input logic r, input logic [31:0] rpc);
    if (m_boot) return m_addr;
    if (r) return {rpc[31:2], 2'b00};
    if (s) return m_addr;
    return m_addr + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid();
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("if_pc", if_pc, m_pc);
    chk("if_ins", if_ins, m_ins);
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_stalls", stat_stalls, m_stalls);
    chk("stat_redirects", stat_redirects, m_redirects);
`endif
  endtask

  // one cycle: apply inputs, check combinational address, clock, check IF/ID
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] nxt;
    stall = s; redirect = r; redirect_pc = rpc;
    #1;
    nxt = model_next(s, r, rpc);
    chk("r_addr", r_addr, nxt >> 2);
    @(posedge clk);
    #1;
    if (m_boot) begin
      m_boot = 0;
    end else if (r) begin
      m_valid = 0; m_redirects++;
    end else if (s) begin
      m_stalls++;
    end else begin
      m_valid = 1; m_pc = m_addr; m_ins = word_at(m_addr); m_fetched++;
    end
    m_addr = nxt;
    check_ifid();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst r_addr", r_addr, 32'h0);
    check_ifid();
    @(posedge clk); #1; rst = 0;

    // boot then sequential run
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    chk("seq if_pc", if_pc, 32'h8);
    chk("seq if_ins", if_ins, 32'h1000_0002);
    // stall 3 cycles holding if_pc=8, address constant at 3
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("stall r_addr", r_addr, 32'd3);
    end
    cyc(0, 0, 0);
    chk("resume if_pc", if_pc, 32'hC);
    // redirect to 0x43 -> bubble then 0x40, word 16
    cyc(0, 1, 32'h0000_0043);
    chk("redir bubble", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0);
    chk("redir if_pc", if_pc, 32'h40);
    chk("redir if_ins", if_ins, 32'h1000_0010);
    cyc(0, 0, 0);
    // redirect and stall together
    cyc(1, 1, 32'h20);
    chk("rs bubble", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0);
    chk("rs if_pc", if_pc, 32'h20);
    // redirect to current fetch address still bubbles
    cyc(0, 1, m_addr);
    cyc(0, 0, 0);
    // wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap hi", if_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap lo", if_pc, 32'h0);
    // async reset mid-cycle
    #2; rst = 1; #1;
    model_reset();
    chk("async r_addr", r_addr, 32'h0);
    check_ifid();
    @(posedge clk); #1; rst = 0;

    // stats scenario: boot, 5 fetches, 2 stalls, 1 redirect
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 32'h100);
`ifdef FETCH_STATS_EN
    chk("stats fetched", stat_fetched, 32'd5);
    chk("stats stalls", stat_stalls, 32'd2);
    chk("stats redirects", stat_redirects, 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      cyc(s, r, $urandom);
    end

    // reset clears everything
    #2; rst = 1; #1;
    model_reset();
    check_ifid();
    @(posedge clk); #1; rst = 0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("post-rst if_pc", if_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
